// File: rtl/vx_tl_pkg.sv
// rtl/vx_tl_pkg.sv - TileLink-UL opcodes and the byteen to A-channel encoding shared by the cache paths
package vx_tl_pkg;

    localparam logic [2:0] TL_GET         = 3'd4;
    localparam logic [2:0] TL_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_ACK         = 3'd0;
    localparam logic [2:0] TL_ACK_DATA    = 3'd1;

    typedef struct packed {
        logic       none;
        logic [2:0] opcode;
        logic [3:0] size;
        logic [1:0] offset;
        logic [3:0] mask;
    } tl_enc_t;

    // Naturally aligned 1/2/4-byte writes go out as PutFull; anything else is a PutPartial word.
    function automatic tl_enc_t tl_encode(input logic rw, input logic [3:0] byteen);
        tl_enc_t e;
        e.none   = 1'b0;
        e.opcode = TL_PUT_FULL;
        e.size   = 4'd2;
        e.offset = 2'd0;
        e.mask   = byteen;
        if (!rw) begin
            e.opcode = TL_GET;
            e.mask   = 4'hF;
        end else begin
            case (byteen)
                4'b0000: e.none = 1'b1;
                4'b1111: e.size = 4'd2;
                4'b0011: e.size = 4'd1;
                4'b1100: begin e.size = 4'd1; e.offset = 2'd2; end
                4'b0001: e.size = 4'd0;
                4'b0010: begin e.size = 4'd0; e.offset = 2'd1; end
                4'b0100: begin e.size = 4'd0; e.offset = 2'd2; end
                4'b1000: begin e.size = 4'd0; e.offset = 2'd3; end
                default: e.opcode = TL_PUT_PARTIAL;
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/vx_tl_source_alloc.sv
// rtl/vx_tl_source_alloc.sv - busy bitmap with lowest-free source allocation and busy count
module vx_tl_source_alloc #(
    parameter  int NUM_SOURCES = 16,
    localparam int IDW         = $clog2(NUM_SOURCES)
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_alloc_en,
    input  logic                   i_free_en,
    input  logic [IDW-1:0]         i_free_id,
    output logic [IDW-1:0]         o_alloc_id,
    output logic                   o_any_free,
    output logic [NUM_SOURCES-1:0] o_busy,
    output logic [IDW:0]           o_count
);

    logic [NUM_SOURCES-1:0] r_busy;
    logic [IDW-1:0]         w_alloc_id;
    logic                   w_any_free;
    logic [IDW:0]           w_count;

    always_comb begin
        w_alloc_id = '0;
        w_any_free = 1'b0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_alloc_id = IDW'(i);
                w_any_free = 1'b1;
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            w_count = w_count + (IDW+1)'(r_busy[i]);
        end
    end

    // Allocation picks from the pre-free bitmap, so a source freed this cycle is only reusable next cycle.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_busy <= '0;
        end else begin
            if (i_alloc_en) r_busy[w_alloc_id] <= 1'b1;
            if (i_free_en)  r_busy[i_free_id]  <= 1'b0;
        end
    end

    assign o_alloc_id = w_alloc_id;
    assign o_any_free = w_any_free;
    assign o_busy     = r_busy;
    assign o_count    = w_count;

endmodule

// File: rtl/vx_tl_dmem_source_tracker.sv
// rtl/vx_tl_dmem_source_tracker.sv - dcache request/response to TileLink-UL A/D bridge with source-ID tag table
module vx_tl_dmem_source_tracker
    import vx_tl_pkg::*;
#(
    parameter int NUM_SOURCES  = 16,
    parameter int SOURCE_WIDTH = 8,
    parameter int TAG_WIDTH    = 8,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    input  logic                          req_rw,
    input  logic [3:0]                    req_byteen,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [31:0]                   req_data,
    input  logic [TAG_WIDTH-1:0]          req_tag,
    output logic                          req_ready,
    output logic                          rsp_valid,
    output logic [31:0]                   rsp_data,
    output logic [TAG_WIDTH-1:0]          rsp_tag,
    output logic                          rsp_error,
    input  logic                          rsp_ready,
    output logic                          a_valid,
    input  logic                          a_ready,
    output logic [2:0]                    a_opcode,
    output logic [3:0]                    a_size,
    output logic [SOURCE_WIDTH-1:0]       a_source,
    output logic [ADDR_WIDTH-1:0]         a_address,
    output logic [3:0]                    a_mask,
    output logic [31:0]                   a_data,
    input  logic                          d_valid,
    output logic                          d_ready,
    input  logic [2:0]                    d_opcode,
    input  logic [SOURCE_WIDTH-1:0]       d_source,
    input  logic [31:0]                   d_data,
    input  logic                          d_denied,
    input  logic                          d_corrupt,
    output logic [$clog2(NUM_SOURCES):0]  outstanding,
    output logic                          err_bad_source
);

    localparam int IDW = $clog2(NUM_SOURCES);

    tl_enc_t                w_enc;
    logic                   w_any_free;
    logic [IDW-1:0]         w_alloc_id;
    logic [NUM_SOURCES-1:0] w_busy;
    logic                   w_req_fire;
    logic                   w_alloc;
    logic                   w_d_fire;
    logic                   w_src_in_range;
    logic [IDW-1:0]         w_d_id;
    logic                   w_src_busy;
    logic                   w_free;
    logic                   w_rsp_load;
    logic                   w_unused_addr_lsb;

    logic                    r_a_valid;
    logic [2:0]              r_a_opcode;
    logic [3:0]              r_a_size;
    logic [SOURCE_WIDTH-1:0] r_a_source;
    logic [ADDR_WIDTH-1:0]   r_a_address;
    logic [3:0]              r_a_mask;
    logic [31:0]             r_a_data;
    logic                    r_rsp_valid;
    logic [31:0]             r_rsp_data;
    logic [TAG_WIDTH-1:0]    r_rsp_tag;
    logic                    r_rsp_error;
    logic                    r_err_bad_source;
    logic [TAG_WIDTH-1:0]    r_tag_table [NUM_SOURCES];

    assign w_enc             = tl_encode(req_rw, req_byteen);
    assign w_unused_addr_lsb = ^req_addr[1:0];

    assign req_ready  = ~reset & (~r_a_valid | a_ready) & w_any_free;
    assign w_req_fire = req_valid & req_ready;
    assign w_alloc    = w_req_fire & ~w_enc.none;

    // Write acks never occupy the response register, so they are always drainable.
    assign d_ready        = ~reset & (~r_rsp_valid | rsp_ready | (d_opcode == TL_ACK));
    assign w_d_fire       = d_valid & d_ready;
    assign w_src_in_range = {1'b0, d_source} < (SOURCE_WIDTH+1)'(NUM_SOURCES);
    assign w_d_id         = d_source[IDW-1:0];
    assign w_src_busy     = w_src_in_range & w_busy[w_d_id];
    assign w_free         = w_d_fire & w_src_busy;
    assign w_rsp_load     = w_free & (d_opcode == TL_ACK_DATA);

    vx_tl_source_alloc #(
        .NUM_SOURCES (NUM_SOURCES)
    ) u_alloc (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_alloc_en (w_alloc),
        .i_free_en  (w_free),
        .i_free_id  (w_d_id),
        .o_alloc_id (w_alloc_id),
        .o_any_free (w_any_free),
        .o_busy     (w_busy),
        .o_count    (outstanding)
    );

    always_ff @(posedge clock) begin
        if (w_alloc) r_tag_table[w_alloc_id] <= req_tag;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a_valid   <= 1'b0;
            r_a_opcode  <= '0;
            r_a_size    <= '0;
            r_a_source  <= '0;
            r_a_address <= '0;
            r_a_mask    <= '0;
            r_a_data    <= '0;
        end else if (w_alloc) begin
            r_a_valid   <= 1'b1;
            r_a_opcode  <= w_enc.opcode;
            r_a_size    <= w_enc.size;
            r_a_source  <= SOURCE_WIDTH'(w_alloc_id);
            r_a_address <= {req_addr[ADDR_WIDTH-1:2], w_enc.offset};
            r_a_mask    <= w_enc.mask;
            r_a_data    <= req_data;
        end else if (a_ready) begin
            r_a_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_tag   <= '0;
            r_rsp_error <= 1'b0;
        end else if (w_rsp_load) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= d_data;
            r_rsp_tag   <= r_tag_table[w_d_id];
            r_rsp_error <= d_denied | d_corrupt;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_err_bad_source <= 1'b0;
        end else if (w_d_fire & ~w_src_busy) begin
            r_err_bad_source <= 1'b1;
        end
    end

    assign a_valid        = r_a_valid;
    assign a_opcode       = r_a_opcode;
    assign a_size         = r_a_size;
    assign a_source       = r_a_source;
    assign a_address      = r_a_address;
    assign a_mask         = r_a_mask;
    assign a_data         = r_a_data;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign rsp_tag        = r_rsp_tag;
    assign rsp_error      = r_rsp_error;
    assign err_bad_source = r_err_bad_source;

endmodule

// File: tb/tb_vx_tl_dmem_source_tracker.sv
// tb/tb_vx_tl_dmem_source_tracker.sv - scoreboard bench with a transaction-level model of the source tracker
module tb_vx_tl_dmem_source_tracker;

    localparam int N  = 16;
    localparam int SW = 8;
    localparam int TW = 8;
    localparam int AW = 32;
    localparam int CW = $clog2(N) + 1;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0, req_rw = 1'b0;
    logic [3:0]    req_byteen = '0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_data = '0;
    logic [TW-1:0] req_tag = '0;
    logic          req_ready;
    logic          rsp_valid, rsp_error;
    logic [31:0]   rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          rsp_ready = 1'b1;
    logic          a_valid;
    logic          a_ready = 1'b1;
    logic [2:0]    a_opcode;
    logic [3:0]    a_size, a_mask;
    logic [SW-1:0] a_source;
    logic [AW-1:0] a_address;
    logic [31:0]   a_data;
    logic          d_valid = 1'b0, d_ready;
    logic [2:0]    d_opcode = '0;
    logic [SW-1:0] d_source = '0;
    logic [31:0]   d_data = '0;
    logic          d_denied = 1'b0, d_corrupt = 1'b0;
    logic [CW-1:0] outstanding;
    logic          err_bad_source;

    always #5 clock = ~clock;

    vx_tl_dmem_source_tracker #(
        .NUM_SOURCES(N), .SOURCE_WIDTH(SW), .TAG_WIDTH(TW), .ADDR_WIDTH(AW)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_byteen(req_byteen), .req_addr(req_addr),
        .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_error(rsp_error),
        .rsp_ready(rsp_ready),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
        .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_source(d_source),
        .d_data(d_data), .d_denied(d_denied), .d_corrupt(d_corrupt),
        .outstanding(outstanding), .err_bad_source(err_bad_source)
    );

    typedef struct {
        logic [2:0]    op;
        logic [3:0]    size;
        logic [SW-1:0] src;
        logic [AW-1:0] addr;
        logic [3:0]    mask;
        logic [31:0]   data;
    } a_exp_t;

    typedef struct {
        logic [31:0]   data;
        logic [TW-1:0] tag;
        logic          err;
    } r_exp_t;

    a_exp_t exp_a[$];
    r_exp_t exp_r[$];

    int n_checks = 0;
    int n_fail   = 0;

    bit            m_busy [N];
    logic [TW-1:0] m_tag [N];
    bit            m_isread [N];
    bit            m_a_full, m_rsp_full, m_err;
    bit            m_req_fired, m_d_fired;
    bit            rr_toggle = 1'b0;

    logic [AW-1:0] last_a_addr;
    logic [SW-1:0] last_a_src;
    logic [2:0]    last_a_op;
    logic [3:0]    last_a_size, last_a_mask;
    logic [31:0]   last_rsp_data;
    logic [TW-1:0] last_rsp_tag;
    logic          last_rsp_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A write is a PutFull only when its lanes form a naturally aligned power-of-two run.
    function automatic void tl_model(input bit rw, input logic [3:0] be, output bit none,
                                     output logic [2:0] op, output logic [3:0] size,
                                     output logic [1:0] off, output logic [3:0] mask);
        int n, lo;
        none = 1'b0; op = 3'd0; size = 4'd2; off = 2'd0; mask = be;
        if (!rw) begin
            op = 3'd4;
            mask = 4'hF;
            return;
        end
        n = $countones(be);
        if (n == 0) begin
            none = 1'b1;
            return;
        end
        lo = 0;
        while (!be[lo]) lo++;
        if ((n == 1 || n == 2 || n == 4) && (be == 4'(((1 << n) - 1) << lo)) && (lo % n == 0)) begin
            size = 4'($clog2(n));
            off  = 2'(lo);
        end else begin
            op = 3'd1;
        end
    endfunction

    task automatic step();
        int cnt, id, src;
        bit exp_rr, exp_dr, nxt_a, nxt_r, src_busy, none;
        logic [2:0] op;
        logic [3:0] sz, mk;
        logic [1:0] off;
        a_exp_t ea;
        r_exp_t er;
        @(negedge clock);
        cnt = 0;
        for (int i = 0; i < N; i++) cnt += int'(m_busy[i]);
        exp_rr = !reset && (!m_a_full || a_ready) && (cnt < N);
        exp_dr = !reset && (!m_rsp_full || rsp_ready || d_opcode == OP_ACK);
        check("req_ready", req_ready, exp_rr);
        check("d_ready", d_ready, exp_dr);
        check("a_valid", a_valid, m_a_full);
        check("rsp_valid", rsp_valid, m_rsp_full);
        check("outstanding", outstanding, cnt);
        check("err_bad_source", err_bad_source, m_err);
        m_req_fired = req_valid && exp_rr;
        m_d_fired   = d_valid && exp_dr;
        if (reset) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
            m_a_full = 1'b0; m_rsp_full = 1'b0; m_err = 1'b0;
            exp_a.delete();
            exp_r.delete();
        end else begin
            nxt_a = m_a_full && !a_ready;
            nxt_r = m_rsp_full && !rsp_ready;
            src = int'(d_source);
            src_busy = (src < N) ? m_busy[src] : 1'b0;
            id = -1;
            if (m_req_fired) begin
                tl_model(req_rw, req_byteen, none, op, sz, off, mk);
                if (!none) begin
                    for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) id = i;
                    ea = '{op, sz, SW'(id), {req_addr[AW-1:2], off}, mk, req_data};
                    exp_a.push_back(ea);
                    m_tag[id] = req_tag;
                    m_isread[id] = !req_rw;
                    nxt_a = 1'b1;
                end
            end
            if (m_d_fired) begin
                if (src_busy) begin
                    if (d_opcode == OP_ACK_DATA) begin
                        er = '{d_data, m_tag[src], d_denied | d_corrupt};
                        exp_r.push_back(er);
                        nxt_r = 1'b1;
                    end
                    m_busy[src] = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (id >= 0) m_busy[id] = 1'b1;
            m_a_full = nxt_a;
            m_rsp_full = nxt_r;
        end
        @(posedge clock);
        #1;
        if (rr_toggle) rsp_ready = !rsp_ready;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_req(input bit rw, input logic [3:0] be, input logic [AW-1:0] addr,
                            input logic [31:0] data, input logic [TW-1:0] tag);
        int k;
        req_valid = 1'b1; req_rw = rw; req_byteen = be; req_addr = addr; req_data = data; req_tag = tag;
        k = 0;
        do begin
            step();
            k++;
        end while (!m_req_fired && k < 100);
        check("req_accept_timeout", m_req_fired, 1);
        req_valid = 1'b0;
    endtask

    task automatic send_d(input logic [2:0] op, input int src, input logic [31:0] data,
                          input bit den, input bit cor);
        int k;
        d_valid = 1'b1; d_opcode = op; d_source = SW'(src); d_data = data; d_denied = den; d_corrupt = cor;
        k = 0;
        do begin
            step();
            k++;
        end while (!m_d_fired && k < 100);
        check("d_accept_timeout", m_d_fired, 1);
        d_valid = 1'b0; d_denied = 1'b0; d_corrupt = 1'b0;
    endtask

    always @(negedge clock) begin
        if (!reset && a_valid && a_ready) begin
            check("a_beat_expected", exp_a.size() > 0, 1);
            if (exp_a.size() > 0) begin
                a_exp_t e;
                e = exp_a.pop_front();
                check("a_opcode", a_opcode, e.op);
                check("a_size", a_size, e.size);
                check("a_source", a_source, e.src);
                check("a_address", a_address, e.addr);
                check("a_mask", a_mask, e.mask);
                check("a_data", a_data, e.data);
            end
            last_a_addr = a_address; last_a_src = a_source; last_a_op = a_opcode;
            last_a_size = a_size; last_a_mask = a_mask;
        end
    end

    always @(negedge clock) begin
        if (!reset && rsp_valid && rsp_ready) begin
            check("rsp_expected", exp_r.size() > 0, 1);
            if (exp_r.size() > 0) begin
                r_exp_t e;
                e = exp_r.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_tag", rsp_tag, e.tag);
                check("rsp_error", rsp_error, e.err);
            end
            last_rsp_data = rsp_data; last_rsp_tag = rsp_tag; last_rsp_err = rsp_error;
        end
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        step();
        reset = 1'b0;
        step();

        // Single read and its data response.
        send_req(1'b0, 4'hF, 32'h1004, 32'h0, 8'h2A);
        idle(2);
        check("t1_a_addr", last_a_addr, 32'h1004);
        check("t1_a_src", last_a_src, 0);
        check("t1_a_op", last_a_op, 3'd4);
        send_d(OP_ACK_DATA, 0, 32'hDEADBEEF, 1'b0, 1'b0);
        idle(2);
        check("t1_rsp_data", last_rsp_data, 32'hDEADBEEF);
        check("t1_rsp_tag", last_rsp_tag, 8'h2A);

        // Sub-word writes.
        send_req(1'b1, 4'b0100, 32'h2000, 32'h11223344, 8'h01);
        send_req(1'b1, 4'b1100, 32'h2000, 32'h55667788, 8'h02);
        send_req(1'b1, 4'b0110, 32'h2000, 32'h99AABBCC, 8'h03);
        idle(2);
        check("t2_a_op", last_a_op, 3'd1);
        check("t2_a_mask", last_a_mask, 4'b0110);
        check("t2_a_addr", last_a_addr, 32'h2000);
        for (int s = 0; s < 3; s++) send_d(OP_ACK, s, 32'h0, 1'b0, 1'b0);
        idle(2);

        // Exhaust all sources, then free one.
        for (int i = 0; i < N; i++) send_req(1'b0, 4'hF, 32'h3000 + 4 * i, 32'h0, TW'(8'h40 + i));
        idle(2);
        check("t3_outstanding", outstanding, N);
        check("t3_req_ready", req_ready, 0);
        send_d(OP_ACK_DATA, 9, 32'h0909_0909, 1'b0, 1'b0);
        send_req(1'b0, 4'hF, 32'h4000, 32'h0, 8'h99);
        idle(2);
        check("t3_realloc_src", last_a_src, 9);

        // Out-of-order returns with a flapping response consumer.
        rr_toggle = 1'b1;
        send_d(OP_ACK_DATA, 3, 32'h3333_0003, 1'b0, 1'b0);
        send_d(OP_ACK_DATA, 1, 32'h1111_0001, 1'b0, 1'b0);
        send_d(OP_ACK_DATA, 2, 32'h2222_0002, 1'b0, 1'b0);
        idle(6);
        rr_toggle = 1'b0;
        rsp_ready = 1'b1;
        idle(2);

        // Bad source and denied response.
        send_d(OP_ACK_DATA, 5, 32'h5555_5555, 1'b0, 1'b0);
        send_d(OP_ACK_DATA, 5, 32'h5555_AAAA, 1'b0, 1'b0);
        idle(2);
        check("t5_err_sticky", err_bad_source, 1);
        send_d(OP_ACK_DATA, 0, 32'h0BAD_0000, 1'b1, 1'b0);
        idle(2);
        check("t5_rsp_error", last_rsp_err, 1);
        for (int s = 0; s < N; s++) if (m_busy[s]) send_d(OP_ACK_DATA, s, 32'(s), 1'b0, 1'b0);
        idle(2);

        // Reset mid-operation with a stalled A beat.
        for (int i = 0; i < 3; i++) send_req(1'b0, 4'hF, 32'h5000 + 4 * i, 32'h0, TW'(i));
        idle(1);
        a_ready = 1'b0;
        send_req(1'b0, 4'hF, 32'h5010, 32'h0, 8'h77);
        idle(1);
        check("t6_pre_outstanding", outstanding, 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_ready = 1'b1;
        step();
        send_req(1'b0, 4'hF, 32'h6000, 32'h0, 8'h61);
        idle(2);
        check("t6_first_src", last_a_src, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if (!req_valid || m_req_fired) begin
                req_valid  = ($urandom_range(0, 3) != 0);
                req_rw     = 1'($urandom);
                req_byteen = 4'($urandom);
                req_addr   = $urandom;
                req_data   = $urandom;
                req_tag    = TW'($urandom);
            end
            a_ready   = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!d_valid || m_d_fired) begin
                int busy_list[$];
                int s;
                for (int i = 0; i < N; i++) if (m_busy[i]) busy_list.push_back(i);
                if (busy_list.size() == 0 || $urandom_range(0, 19) == 0) s = $urandom_range(0, 31);
                else s = busy_list[$urandom_range(0, busy_list.size() - 1)];
                d_valid   = ($urandom_range(0, 2) != 0);
                d_source  = SW'(s);
                d_opcode  = (s < N && m_isread[s]) ? OP_ACK_DATA : OP_ACK;
                if ($urandom_range(0, 15) == 0) d_opcode = ~d_opcode & 3'd1;
                d_data    = $urandom;
                d_denied  = ($urandom_range(0, 7) == 0);
                d_corrupt = ($urandom_range(0, 7) == 0);
            end
            step();
        end

        req_valid = 1'b0; d_valid = 1'b0; a_ready = 1'b1; rsp_ready = 1'b1;
        idle(5);
        check("a_queue_drained", exp_a.size(), 0);
        check("rsp_queue_drained", exp_r.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
